// File: rtl/pov_col_sched_if.sv
// pov_col_sched_if: host write handshake, column RAM control port and
// display status for the POV column scheduler.
// master = scheduler side, slave = host / RAM / LED side.
interface pov_col_sched_if #(
    parameter int AW = 8
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          ram_re;
    logic          col_strobe;
    logic          blank;
    logic          running;

    modport master (
        input  wr_req, wr_addr,
        output wr_ack, ram_addr, ram_we, ram_re, col_strobe, blank, running
    );

    modport slave (
        output wr_req, wr_addr,
        input  wr_ack, ram_addr, ram_we, ram_re, col_strobe, blank, running
    );
endinterface

// File: rtl/pov_col_sched.sv
// pov_col_sched: spreads NCOL column reads evenly over one rotor revolution
// using the measured hall period, and shares the single RAM port with host
// column writes (display reads win, writes fill the free slots).
// Optional build macro POV_REV_DIR_EN: reversed rotor, columns read NCOL-1..0.
module pov_col_sched #(
    parameter int            NCOL       = 160,
    parameter int            AW         = 8,
    parameter int            PW         = 24,
    parameter logic [PW-1:0] MAX_PERIOD = 24'hFFFFFF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hall,
    pov_col_sched_if.master bus
);
    localparam logic [1:0] WAIT1 = 2'd0;
    localparam logic [1:0] MEAS  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    localparam logic [AW-1:0] COL_LAST = AW'(NCOL - 1);
    localparam logic [AW:0]   COL_NUM  = (AW+1)'(NCOL);
    localparam logic [PW-1:0] MIN_PER  = PW'(2 * NCOL);
    localparam logic [PW:0]   STEP     = (PW+1)'(NCOL);

    logic          hall_q;
    logic          hall_edge;
    logic [PW-1:0] per_cnt;
    logic [PW-1:0] period;
    logic [PW-1:0] new_per;
    logic          per_ok;
    logic          stall;
    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          resync;
    logic          run_step;
    logic [AW-1:0] col;
    logic [PW:0]   acc;
    logic [PW:0]   acc_nx;
    logic          step_ovf;
    logic          rd_pend;
    logic [AW-1:0] disp_addr;

    assign hall_edge = hall & ~hall_q;
    assign new_per   = per_cnt + 1'b1;
    assign per_ok    = (new_per >= MIN_PER);
    // An edge restarts the period count, so it never counts as a stall.
    assign stall     = (per_cnt == MAX_PERIOD) && !hall_edge;

    // Bresenham-style column pacing: NCOL steps per 'period' cycles.
    assign acc_nx    = acc + STEP;
    assign step_ovf  = (acc_nx >= {1'b0, period});

`ifdef POV_REV_DIR_EN
    assign disp_addr = COL_LAST - col;
`else
    assign disp_addr = col;
`endif

    // Hall edge detector register.
    always_ff @(posedge clk) begin
        if (reset) hall_q <= 1'b0;
        else       hall_q <= hall;
    end

    // Period counter: restarts on each index, saturates at the stall limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt <= '0;
            period  <= '0;
        end else if (hall_edge) begin
            per_cnt <= '0;
            period  <= new_per;
        end else if (per_cnt != MAX_PERIOD) begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    // Next state: a stall drops to WAIT1 from anywhere; edges advance.
    always_comb begin
        state_nx = state;
        if (stall) begin
            state_nx = WAIT1;
        end else if (hall_edge) begin
            case (state)
                WAIT1:   state_nx = MEAS;
                MEAS:    state_nx = per_ok ? RUN : MEAS;
                RUN:     state_nx = per_ok ? RUN : MEAS;
                default: state_nx = WAIT1;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= WAIT1;
        else       state <= state_nx;
    end

    assign resync   = hall_edge && (state_nx == RUN);
    assign run_step = (state == RUN) && !hall_edge && !stall;

    // Column stepping. rd_pend lives for one cycle only, because the arbiter
    // serves it unconditionally; leaving RUN therefore drops it implicitly.
    always_ff @(posedge clk) begin
        if (reset) begin
            col     <= '0;
            acc     <= '0;
            rd_pend <= 1'b0;
        end else if (resync) begin
            col     <= '0;
            acc     <= '0;
            rd_pend <= 1'b1;
        end else if (run_step) begin
            rd_pend <= 1'b0;
            if (step_ovf) begin
                acc <= acc_nx - {1'b0, period};
                // Past the last column, overflows are swallowed until the
                // next index so a slowing rotor never wraps the image.
                if (col != COL_LAST) begin
                    col     <= col + 1'b1;
                    rd_pend <= 1'b1;
                end
            end else begin
                acc <= acc_nx;
            end
        end else begin
            rd_pend <= 1'b0;
        end
    end

    // RAM port arbiter: display read first, then a host write not already
    // granted last cycle. Out-of-range writes are acked but not performed.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.ram_addr   <= '0;
            bus.ram_we     <= 1'b0;
            bus.ram_re     <= 1'b0;
            bus.col_strobe <= 1'b0;
            bus.wr_ack     <= 1'b0;
        end else if (rd_pend) begin
            bus.ram_addr   <= disp_addr;
            bus.ram_we     <= 1'b0;
            bus.ram_re     <= 1'b1;
            bus.col_strobe <= 1'b1;
            bus.wr_ack     <= 1'b0;
        end else if (bus.wr_req && !bus.wr_ack) begin
            bus.ram_re     <= 1'b0;
            bus.col_strobe <= 1'b0;
            bus.wr_ack     <= 1'b1;
            if ({1'b0, bus.wr_addr} < COL_NUM) begin
                bus.ram_we   <= 1'b1;
                bus.ram_addr <= bus.wr_addr;
            end else begin
                bus.ram_we   <= 1'b0;
            end
        end else begin
            bus.ram_we     <= 1'b0;
            bus.ram_re     <= 1'b0;
            bus.col_strobe <= 1'b0;
            bus.wr_ack     <= 1'b0;
        end
    end

    assign bus.blank   = (state != RUN);
    assign bus.running = (state == RUN);

endmodule

// File: doc/pov_col_sched.md
Name: pov_col_sched

Overview:
- Sequences the POV column RAM. Spreads NCOL display column reads evenly over one rotor revolution, using the measured hall-sensor period.
- Arbitrates the single RAM address/control port between display reads and host column writes.
- Sits between the hall-sensor input, the host write path and the column RAM. The LED shift-out logic consumes col_strobe.

Parameters:
- NCOL, 160, columns per revolution
- AW, 8, RAM address width
- PW, 24, period counter width
- MAX_PERIOD, 24'hFFFFFF, stall timeout in clk cycles

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- hall  in  1  hall sensor level, already synchronised to clk; rising edge = index
- wr_req  in  1  host column write request; held until wr_ack
- wr_addr  in  AW  host write column address
- wr_ack  out  1  one-cycle write grant
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- col_strobe  out  1  display read issued; RAM data valid the following cycle
- blank  out  1  LEDs must be dark
- running  out  1  state == RUN

Behaviour:
- Registered outputs. Reset values: ram_addr=0, ram_we=0, ram_re=0, col_strobe=0, wr_ack=0, blank=1, running=0. Arbiter decisions taken in cycle k are visible at k+1.
- Edge detection: edge = hall & ~hall_q, with hall_q registered.
- per_cnt (PW bits):
  - edge: per_cnt <= 0 and period <= per_cnt+1 (cycles between edges).
  - otherwise: per_cnt increments, saturating at MAX_PERIOD.
- FSM states WAIT1, MEAS, RUN; reset enters WAIT1.
  - WAIT1 -> MEAS on first edge.
  - MEAS -> RUN on next edge if the new period >= 2*NCOL. Otherwise stay in MEAS.
  - RUN -> RUN on edge if period >= 2*NCOL. Otherwise RUN -> MEAS and rd_pend is cleared.
  - Any state -> WAIT1 when per_cnt reaches MAX_PERIOD (stall).
  - blank = (state != RUN).
- Column stepping (RUN only), using col (AW bits) and acc (PW+1 bits):
  - On edge (entering or staying in RUN): col <= 0, acc <= 0, rd_pend <= 1. Every revolution resyncs to column 0.
  - Otherwise, if acc+NCOL >= period: acc <= acc+NCOL-period, col <= col+1, rd_pend <= 1.
  - Otherwise: acc <= acc+NCOL.
  - col saturates at NCOL-1 (no wrap) until the next edge. Further overflows are ignored.
  - Result: exactly NCOL reads per steady revolution, spaced floor or ceil of period/NCOL cycles.
- Arbitration, evaluated each cycle, fixed priority:
  1. rd_pend: ram_re=1, ram_addr=col, col_strobe=1; clear rd_pend.
  2. Else, if wr_req and wr_ack is currently 0: wr_ack=1; if wr_addr < NCOL then ram_we=1 and ram_addr=wr_addr, otherwise ram_we=0 (write dropped, still acked).
  3. Else: ram_re=0, ram_we=0, ram_addr holds its value.
- Write wait bound: the 2*NCOL minimum period gives at least one free slot between reads, so a write waits at most 2 cycles in RUN.
- wr_req is ignored in the cycle wr_ack=1, so there is no double grant.
- Writes are accepted in every state, including while blank.
- A new step landing while rd_pend=1: pending read re-targets the newest col. Cannot occur with a legal period; no queueing.
- Reset mid-operation: all state and outputs return to reset values the next cycle. An in-flight grant is lost and the requester re-requests.

Optional Feature:
- Macro POV_REV_DIR_EN (reversed rotor direction).
- Defined: display address = NCOL-1-col, so reads run 159..0; column 0 of RAM is read last.
- Undefined: display address = col (0..159).
- Write path unaffected in both cases.

Test Plan:
- Edges every 1600 cycles -> after 2 edges running=1, blank=0; reads at col 0..159 spaced exactly 10 cycles; 160 col_strobes per revolution.
- Period 1605 -> 160 reads per revolution with spacings 10 or 11 (five 11s); col 0 read on the cycle after each edge's decision.
- Continuous wr_req to addrs 0..159 during RUN at period 1600 -> every write acked within 2 cycles; no read missed or delayed >1 cycle; no ram_we and ram_re in the same cycle.
- wr_req with wr_addr=200 -> wr_ack=1, ram_we=0.
- Edges stop -> after MAX_PERIOD cycles (set MAX_PERIOD=5000 in bench) state WAIT1, blank=1, no further col_strobe. Edge period 300 (<320) while in RUN -> MEAS, blank=1.
- reset pulsed mid-revolution -> next cycle all outputs at reset values; re-sync requires 2 fresh edges.
